branch_resolve_queue: RTL and testbench
=======================================

// Module: branch_resolve_queue
// PURPOSE
//  In-order FIFO of in-flight control-flow predictions, sitting between IF and EX.
//  IF pushes each predicted branch/jal/jalr: pc, predicted direction, global-history snapshot.
//  EX resolves entries oldest-first. The block produces the registered one-cycle update
//  (enable, pc, mispredict, history) that trains the local prediction table and global history.
//  On a misprediction it empties itself and raises a flush pulse for the front end.
// PARAMETERS
//  DEPTH      8   entries; power of two, >=2
//  s_history  7   global-history width; must match the prediction table
// PORTS
//  clk                 in   1          clock
//  rst                 in   1          asynchronous, active-high reset
//  push_valid          in   1          IF has a predicted control-flow instr
//  push_pc             in   32         rv32i_word, pc of that instr
//  push_pred           in   1          predictmux_t, predicted direction
//  push_g_history      in   s_history  history snapshot at prediction time
//  push_ready          out  1          = !full
//  resolve_valid       in   1          EX resolves the oldest entry
//  resolve_pc          in   32         pc of the resolving instr (consistency check)
//  resolve_taken       in   1          actual direction
//  ext_flush           in   1          pipeline flush from elsewhere (trap, etc.)
//  upd_en              out  1          predict_en to the prediction table / history
//  upd_pc              out  32         resolved_pc
//  upd_mispredict      out  1          predictionFailed
//  upd_g_history       out  s_history  resolved_g_history
//  mispredict_flush    out  1          front-end redirect/flush pulse
//  order_error         out  1          sticky: resolve with empty queue or pc mismatch
//  br_count            out  32         resolved-entry count, saturating
//  mispred_count       out  32         mispredict count, saturating
// BEHAVIOUR
//  Reset (async): pointers and count 0. All upd_* 0. mispredict_flush 0, order_error 0,
//   both counters 0. Entry storage is not reset.
//  Storage: rd_ptr/wr_ptr are $clog2(DEPTH)+1 bits; the MSB disambiguates full/empty.
//   Index = low bits; wraps naturally. full = idx equal && MSB differ; empty = ptrs equal.
//  Push: accepted iff push_valid && push_ready && !ext_flush && !mispredict_now.
//   Entry is written at wr_ptr; wr_ptr increments.
//   When full, push_ready=0 even if a pop occurs in the same cycle (no bypass).
//  Resolve: valid iff resolve_valid && !empty. Head entry popped; rd_ptr increments.
//   mispredict_now = (head.pred==taken) != resolve_taken.
//   At the next edge: upd_en=1, upd_pc=head.pc, upd_mispredict=mispredict_now,
//   upd_g_history=head.g_history. Otherwise upd_en=0 and the upd_* data regs hold their value.
//  Latency: resolve to upd_en/mispredict_flush is exactly 1 cycle (registered).
//  Mispredict: at the same edge, rd_ptr<=wr_ptr<=0 (all younger entries discarded);
//   mispredict_flush=1 for one cycle. Simultaneous push is dropped.
//  ext_flush: pointers cleared at the edge. Takes priority over push.
//   If a valid resolve occurs in the same cycle, its update is still emitted.
//  Simultaneous push+resolve (not full, no mispredict): both occur; count unchanged.
//  order_error: set when resolve_valid && empty, or on a valid resolve with
//   resolve_pc != head.pc. The update is still emitted for a pc mismatch; for empty, no update.
//   Cleared only by rst.
//  Counters: br_count++ per valid resolve; mispred_count++ per mispredict.
//   Both saturate at 32'hFFFF_FFFF.
// STRUCTURE
//  Entry typedef bpq_entry_t {rv32i_word pc; predictmux_t pred; logic [s_history-1:0] gh;}.
//   It lives in the shared branch-prediction package with DEPTH and s_history defaults.
//  One sub-module is natural: bpq_fifo (parametric storage plus ptr/full/empty logic).
//   Resolve/update/counter logic sits in the top.
// TESTING
//  1 Reset then push pc=0x40,0x44,0x48 pred=nottaken; resolve 3x taken=0
//    -> 3 upd_en pulses 1 cycle later, pc 0x40/0x44/0x48, mispredict=0, br_count=3.
//  2 Push DEPTH entries -> push_ready=0. A further push is ignored.
//    Push+resolve while full -> push still refused. Next cycle ready=1.
//  3 Push 0x100(pred taken),0x104,0x108; resolve 0x100 taken=0
//    -> upd_mispredict=1, mispredict_flush pulse, queue empty, mispred_count=1.
//    A same-cycle push is dropped.
//  4 Wrap: 3*DEPTH alternating push/resolve, gh=push index
//    -> upd_g_history matches in order; no order_error.
//  5 resolve_valid on empty queue -> no upd_en, order_error=1 sticky.
//    resolve_pc=0x200 vs head 0x204 -> update emitted with pc 0x204, order_error=1.
//  6 ext_flush with 4 entries plus a valid resolve -> update emitted, queue empty next cycle.
//    Assert rst mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/branch_resolve_queue_pkg.sv
// Shared branch-prediction types. This package holds the in-flight prediction entry,
// the default queue geometry and a small saturating-increment helper.
package branch_resolve_queue_pkg;

    // Default geometry. The history width must match the prediction table.
    localparam int BPQ_DEPTH = 8;
    localparam int S_HISTORY = 7;

    typedef logic [31:0] rv32i_word;

    // Predicted direction as produced by the front-end predictor mux.
    typedef enum logic {
        PRED_NOTTAKEN = 1'b0,
        PRED_TAKEN    = 1'b1
    } predictmux_t;

    // One in-flight prediction: where it was, what was guessed, and the
    // global history it was guessed with.
    typedef struct packed {
        rv32i_word             pc;
        predictmux_t           pred;
        logic [S_HISTORY-1:0]  gh;
    } bpq_entry_t;

    // Statistics counters stick at all-ones instead of wrapping to zero.
    function automatic rv32i_word sat_inc(input rv32i_word value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/branch_resolve_queue_fifo.sv
// Storage and pointer logic for the branch resolve queue. The pointers carry one
// extra bit above the index, so the same index with a different wrap bit means
// full and equal pointers mean empty. The clear input has priority over push and
// pop, and it returns both pointers to zero.
module bpq_fifo
    import branch_resolve_queue_pkg::*;
#(
    parameter int DEPTH = BPQ_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  bpq_entry_t wdata,
    input  logic       pop,
    input  logic       clear,
    output bpq_entry_t head,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0]   rd_ptr;
    logic [AW:0]   wr_ptr;
    bpq_entry_t    mem [DEPTH];
    logic          write_en;
    logic          read_en;

    // Pointer compare decides the full and empty flags. Reads and writes are gated here
    // as well, so the pointers stay consistent even if a caller does not check the flags.
    always_comb begin
        full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
        empty    = (wr_ptr == rd_ptr);
        write_en = push && !full;
        read_en  = pop && !empty;
        head     = mem[rd_ptr[AW-1:0]];
    end

    // Pointer state: clear wins, otherwise push and pop advance their pointers independently.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (write_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (read_en)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Entry storage is written at the write pointer.
    // NOTE: the array has no reset. The pointers alone decide which slots hold valid data,
    // so stale contents are never observed, and this keeps the array a plain RAM.
    always_ff @(posedge clk) begin
        if (write_en && !clear) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of in-flight control-flow predictions between IF and EX.
// IF pushes each predicted branch. EX resolves the oldest entry.
// Each resolve produces a registered one-cycle training update. A wrong
// prediction empties the queue and pulses mispredict_flush to redirect the front end.
module branch_resolve_queue
    import branch_resolve_queue_pkg::*;
#(
    parameter int DEPTH     = BPQ_DEPTH,
    parameter int s_history = S_HISTORY
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push_valid,
    input  logic [31:0]          push_pc,
    input  logic                 push_pred,
    input  logic [s_history-1:0] push_g_history,
    output logic                 push_ready,
    input  logic                 resolve_valid,
    input  logic [31:0]          resolve_pc,
    input  logic                 resolve_taken,
    input  logic                 ext_flush,
    output logic                 upd_en,
    output logic [31:0]          upd_pc,
    output logic                 upd_mispredict,
    output logic [s_history-1:0] upd_g_history,
    output logic                 mispredict_flush,
    output logic                 order_error,
    output logic [31:0]          br_count,
    output logic [31:0]          mispred_count
);

    bpq_entry_t head;
    bpq_entry_t push_entry;
    logic       full;
    logic       empty;
    logic       resolve_fire;
    logic       mispredict_now;
    logic       push_fire;
    logic       queue_clear;
    logic       order_violation;

    // Decode this cycle's handshakes. A mispredict or an external flush discards the whole
    // queue, so any push in the same cycle is dropped rather than written behind a redirect.
    // NOTE: every signal in this block gets a value on every path, so no latches are inferred.
    always_comb begin
        push_ready      = !full;
        resolve_fire    = resolve_valid && !empty;
        mispredict_now  = resolve_fire && ((head.pred == PRED_TAKEN) != resolve_taken);
        push_fire       = push_valid && push_ready && !ext_flush && !mispredict_now;
        queue_clear     = ext_flush || mispredict_now;
        order_violation = (resolve_valid && empty) ||
                          (resolve_fire && (resolve_pc != head.pc));
        push_entry.pc   = push_pc;
        push_entry.pred = predictmux_t'(push_pred);
        push_entry.gh   = push_g_history;
    end

    bpq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_fire),
        .wdata (push_entry),
        .pop   (resolve_fire),
        .clear (queue_clear),
        .head  (head),
        .full  (full),
        .empty (empty)
    );

    // Training update: the enable pulses for each resolve, and the data fields hold between resolves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_en         <= 1'b0;
            upd_pc         <= '0;
            upd_mispredict <= 1'b0;
            upd_g_history  <= '0;
        end else begin
            upd_en <= resolve_fire;
            if (resolve_fire) begin
                upd_pc         <= head.pc;
                upd_mispredict <= mispredict_now;
                upd_g_history  <= head.gh;
            end
        end
    end

    // Front-end redirect pulse and the sticky ordering-error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mispredict_flush <= 1'b0;
            order_error      <= 1'b0;
        end else begin
            mispredict_flush <= mispredict_now;
            if (order_violation) order_error <= 1'b1;
        end
    end

    // Saturating statistics: resolved branches and mispredicted branches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_count      <= '0;
            mispred_count <= '0;
        end else begin
            if (resolve_fire)   br_count      <= sat_inc(br_count);
            if (mispredict_now) mispred_count <= sat_inc(mispred_count);
        end
    end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed test of branch_resolve_queue. Expected values are computed by hand.
module tb_branch_resolve_queue;

    localparam int DEPTH = 8;
    localparam int SH    = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          push_valid = 1'b0;
    logic [31:0]   push_pc = '0;
    logic          push_pred = 1'b0;
    logic [SH-1:0] push_g_history = '0;
    logic          push_ready;
    logic          resolve_valid = 1'b0;
    logic [31:0]   resolve_pc = '0;
    logic          resolve_taken = 1'b0;
    logic          ext_flush = 1'b0;
    logic          upd_en;
    logic [31:0]   upd_pc;
    logic          upd_mispredict;
    logic [SH-1:0] upd_g_history;
    logic          mispredict_flush;
    logic          order_error;
    logic [31:0]   br_count;
    logic [31:0]   mispred_count;

    int total = 0;
    int bad   = 0;

    branch_resolve_queue #(.DEPTH(DEPTH), .s_history(SH)) dut (
        .clk              (clk),
        .rst              (rst),
        .push_valid       (push_valid),
        .push_pc          (push_pc),
        .push_pred        (push_pred),
        .push_g_history   (push_g_history),
        .push_ready       (push_ready),
        .resolve_valid    (resolve_valid),
        .resolve_pc       (resolve_pc),
        .resolve_taken    (resolve_taken),
        .ext_flush        (ext_flush),
        .upd_en           (upd_en),
        .upd_pc           (upd_pc),
        .upd_mispredict   (upd_mispredict),
        .upd_g_history    (upd_g_history),
        .mispredict_flush (mispredict_flush),
        .order_error      (order_error),
        .br_count         (br_count),
        .mispred_count    (mispred_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one clock edge, then settle 1ns past it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] pc, input logic pred, input logic [SH-1:0] gh);
        push_valid = 1'b1; push_pc = pc; push_pred = pred; push_g_history = gh;
        step();
        push_valid = 1'b0;
    endtask

    // Resolve the head entry. The registered update is visible right after the edge.
    task automatic resolve_one(input logic [31:0] pc, input logic taken);
        resolve_valid = 1'b1; resolve_pc = pc; resolve_taken = taken;
        step();
        resolve_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        step();
        check("rst_upd_en", 32'(upd_en), 32'd0);
        check("rst_br_count", br_count, 32'd0);
        check("rst_order_error", 32'(order_error), 32'd0);
        check("rst_push_ready", 32'(push_ready), 32'd1);
        rst = 1'b0;
        step();

        // 1: three correct not-taken predictions
        push_one(32'h40, 1'b0, 7'd1);
        push_one(32'h44, 1'b0, 7'd2);
        push_one(32'h48, 1'b0, 7'd3);
        for (int i = 0; i < 3; i++) begin
            resolve_one(32'h40 + 32'(4 * i), 1'b0);
            check("t1_upd_en", 32'(upd_en), 32'd1);
            check("t1_upd_pc", upd_pc, 32'h40 + 32'(4 * i));
            check("t1_mispredict", 32'(upd_mispredict), 32'd0);
            check("t1_gh", 32'(upd_g_history), 32'(i + 1));
        end
        step();
        check("t1_upd_en_drop", 32'(upd_en), 32'd0);
        check("t1_br_count", br_count, 32'd3);

        // 2: fill to full, extra push refused, push+resolve while full refused
        for (int i = 0; i < DEPTH; i++) push_one(32'h1000 + 32'(4 * i), 1'b0, 7'(i));
        check("t2_full_ready", 32'(push_ready), 32'd0);
        push_one(32'h2000, 1'b0, 7'd0);
        push_valid = 1'b1; push_pc = 32'h3000;
        resolve_valid = 1'b1; resolve_pc = 32'h1000; resolve_taken = 1'b0;
        check("t2_ready_during_pop", 32'(push_ready), 32'd0);
        step();
        push_valid = 1'b0; resolve_valid = 1'b0;
        check("t2_ready_after_pop", 32'(push_ready), 32'd1);
        check("t2_pop_pc", upd_pc, 32'h1000);
        for (int i = 1; i < DEPTH; i++) begin
            resolve_one(32'h1000 + 32'(4 * i), 1'b0);
            check("t2_drain_pc", upd_pc, 32'h1000 + 32'(4 * i));
        end
        check("t2_br_count", br_count, 32'd11);
        check("t2_order_error", 32'(order_error), 32'd0);

        // 3: mispredict flushes the queue and drops a same-cycle push
        push_one(32'h100, 1'b1, 7'd9);
        push_one(32'h104, 1'b0, 7'd10);
        push_one(32'h108, 1'b0, 7'd11);
        push_valid = 1'b1; push_pc = 32'h10c; push_pred = 1'b0;
        resolve_one(32'h100, 1'b0);
        push_valid = 1'b0;
        check("t3_upd_en", 32'(upd_en), 32'd1);
        check("t3_upd_pc", upd_pc, 32'h100);
        check("t3_mispredict", 32'(upd_mispredict), 32'd1);
        check("t3_flush", 32'(mispredict_flush), 32'd1);
        check("t3_mispred_count", mispred_count, 32'd1);
        step();
        check("t3_flush_pulse", 32'(mispredict_flush), 32'd0);
        push_one(32'h300, 1'b0, 7'd12);
        resolve_one(32'h300, 1'b0);
        check("t3_empty_after_flush", upd_pc, 32'h300);
        check("t3_order_error", 32'(order_error), 32'd0);
        check("t3_br_count", br_count, 32'd13);

        // 4: wrap the pointers several times with alternating push/resolve
        for (int i = 0; i < 3 * DEPTH; i++) begin
            push_one(32'h400 + 32'(4 * i), 1'b0, 7'(i));
            resolve_one(32'h400 + 32'(4 * i), 1'b0);
            check("t4_gh", 32'(upd_g_history), 32'(i));
        end
        check("t4_order_error", 32'(order_error), 32'd0);
        check("t4_br_count", br_count, 32'd37);

        // 5: resolve on empty, then pc mismatch
        resolve_one(32'h0, 1'b0);
        check("t5_empty_no_upd", 32'(upd_en), 32'd0);
        check("t5_empty_error", 32'(order_error), 32'd1);
        check("t5_empty_br_count", br_count, 32'd37);
        push_one(32'h204, 1'b0, 7'd5);
        resolve_one(32'h200, 1'b0);
        check("t5_mismatch_upd_en", 32'(upd_en), 32'd1);
        check("t5_mismatch_pc", upd_pc, 32'h204);
        step();
        check("t5_sticky", 32'(order_error), 32'd1);

        // 6: ext_flush with a valid resolve, then reset mid-stream
        for (int i = 0; i < 4; i++) push_one(32'h500 + 32'(4 * i), 1'b0, 7'(i));
        ext_flush = 1'b1;
        push_valid = 1'b1; push_pc = 32'h5f0;
        resolve_one(32'h500, 1'b0);
        ext_flush = 1'b0; push_valid = 1'b0;
        check("t6_upd_en", 32'(upd_en), 32'd1);
        check("t6_upd_pc", upd_pc, 32'h500);
        check("t6_br_count", br_count, 32'd39);
        push_one(32'h600, 1'b0, 7'd6);
        resolve_one(32'h600, 1'b0);
        check("t6_empty_after_flush", upd_pc, 32'h600);
        check("t6_mispred_count", mispred_count, 32'd1);
        push_one(32'h700, 1'b0, 7'd7);
        resolve_one(32'h700, 1'b1);
        check("t6_pre_rst_flush", 32'(mispredict_flush), 32'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_upd_en", 32'(upd_en), 32'd0);
        check("t6_rst_upd_pc", upd_pc, 32'd0);
        check("t6_rst_gh", 32'(upd_g_history), 32'd0);
        check("t6_rst_flush", 32'(mispredict_flush), 32'd0);
        check("t6_rst_order_error", 32'(order_error), 32'd0);
        check("t6_rst_br_count", br_count, 32'd0);
        check("t6_rst_mispred_count", mispred_count, 32'd0);
        check("t6_rst_ready", 32'(push_ready), 32'd1);
        step();
        rst = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
